cga_vram_sequencer: RTL and testbench

// Master timing sequencer and VRAM arbiter for the CGA pixel path. Runs the 5-bit character-slot counter
// (clk_seq) and issues the char/attr fetches and datapath strobes (vram_read_char, vram_read_att,

---
 rtl/cga_vram_sequencer_pkg.sv | 28 ++
 rtl/cga_vram_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_cga_vram_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cga_vram_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cga_vram_sequencer_pkg
//  Purpose  : Shared constants for the CGA VRAM sequencer: character-slot
//             positions of the video fetch steps, CPU access FSM encoding
//             and default geometry.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cga_vram_sequencer_pkg;

  localparam int VRAM_AW_DEFAULT  = 14;
  localparam int CPU_SLOT_DEFAULT = 8;

  // Position (clk_seq[3:0]) of each step inside a video phase
  localparam logic [3:0] SLOT_CHAR      = 4'd0;  // even (char) address on the bus
  localparam logic [3:0] SLOT_ATT       = 4'd1;  // odd (attr) address, char byte latched
  localparam logic [3:0] SLOT_ATT_LATCH = 4'd2;  // attr byte latched
  localparam logic [3:0] SLOT_ROM       = 4'd3;  // char ROM lookup + pipeline advance
  localparam logic [3:0] SLOT_LAST      = 4'd15; // last clk of a 16-clk slot

  // CPU access FSM
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cga_vram_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cga_vram_sequencer
//  Purpose  : Master timing sequencer and VRAM arbiter for the CGA pixel
//             path. Runs the 5-bit character-slot counter, issues the video
//             char/attr fetches and pixel strobes, and shares the single VRAM
//             port with ISA CPU accesses granted only in a fixed CPU window.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             hres_mode_i                - 1 = 16-clk char slot, 0 = 32-clk
//             vid_addr_i                 - video fetch address (even byte)
//             cpu_req_i/we_i/addr_i/wdata_i - ISA request side
//             cpu_ack_o, cpu_rdata_o     - ISA completion / read data
//             ram_addr_o/we_o/wdata_o    - VRAM port, ram_rdata_i 1 clk later
//             clk_seq_o                  - free-running slot counter
//             vram_read_char_o, vram_read_att_o, charrom_read_o,
//             disp_pipeline_o, char_tick_o - pixel datapath strobes
//  Revision : 1.0 - initial release
// ============================================================================
module cga_vram_sequencer
  import cga_vram_sequencer_pkg::*;
#(
  parameter int VRAM_AW  = VRAM_AW_DEFAULT,
  parameter int CPU_SLOT = CPU_SLOT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hres_mode_i,
  input  logic [VRAM_AW-1:0] vid_addr_i,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic [VRAM_AW-1:0] cpu_addr_i,
  input  logic [7:0]         cpu_wdata_i,
  output logic               cpu_ack_o,
  output logic [7:0]         cpu_rdata_o,
  output logic [VRAM_AW-1:0] ram_addr_o,
  output logic               ram_we_o,
  output logic [7:0]         ram_wdata_o,
  input  logic [7:0]         ram_rdata_i,
  output logic [4:0]         clk_seq_o,
  output logic               vram_read_char_o,
  output logic               vram_read_att_o,
  output logic               charrom_read_o,
  output logic               disp_pipeline_o,
  output logic               char_tick_o
);

  localparam logic [3:0]         CPU_SLOT_L = 4'(CPU_SLOT);
  localparam logic [VRAM_AW-1:0] ADDR_LSB   = VRAM_AW'(1);

  logic [4:0]         seq_q, seq_d;
  logic               char_q, char_d;
  logic               att_q, att_d;
  logic               rom_q, rom_d;
  logic               tick_q, tick_d;
  logic [1:0]         state_q, state_d;
  logic               ack_q, ack_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [VRAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic               ram_we_q, ram_we_d;
  logic [7:0]         ram_wdata_q, ram_wdata_d;
  logic [VRAM_AW-1:0] cpu_addr_q, cpu_addr_d;
  logic               cpu_we_q, cpu_we_d;
  logic [7:0]         cpu_wdata_q, cpu_wdata_d;

  // All registered outputs are decoded from the counter value of the coming
  // cycle, so each strobe is high exactly during the cycle its slot names.
  logic [3:0] slot_d;
  logic       vphase_d;

  assign seq_d    = seq_q + 5'd1;
  assign slot_d   = seq_d[3:0];
  // In lores the upper half of the 32-clk slot carries no video phase.
  assign vphase_d = hres_mode_i | ~seq_d[4];

  always_comb begin
    char_d      = vphase_d && (slot_d == SLOT_ATT);
    att_d       = vphase_d && (slot_d == SLOT_ATT_LATCH);
    rom_d       = vphase_d && (slot_d == SLOT_ROM);
    tick_d      = hres_mode_i ? (slot_d == SLOT_LAST) : (seq_d == {1'b1, SLOT_LAST});

    state_d     = state_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_we_d    = cpu_we_q;
    cpu_wdata_d = cpu_wdata_q;

    // The VRAM returns data during the ack cycle; keep it for later reads.
    if (ack_q && !cpu_we_q) begin
      rdata_d = ram_rdata_i;
    end

    // Video fetch addresses; CPU_SLOT never coincides with these slots.
    if (vphase_d && (slot_d == SLOT_CHAR)) begin
      ram_addr_d = vid_addr_i & ~ADDR_LSB;
    end else if (vphase_d && (slot_d == SLOT_ATT)) begin
      ram_addr_d = vid_addr_i | ADDR_LSB;
    end

    case (state_q)
      ST_IDLE: begin
        // The request is still held during the ack cycle; ignore it there.
        if (cpu_req_i && !ack_q) begin
          cpu_addr_d  = cpu_addr_i;
          cpu_we_d    = cpu_we_i;
          cpu_wdata_d = cpu_wdata_i;
          if (slot_d == CPU_SLOT_L) begin
            // Request arriving just before the window is served at once.
            state_d     = ST_ACCESS;
            ram_addr_d  = cpu_addr_i;
            ram_we_d    = cpu_we_i;
            ram_wdata_d = cpu_wdata_i;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (slot_d == CPU_SLOT_L) begin
          state_d     = ST_ACCESS;
          ram_addr_d  = cpu_addr_q;
          ram_we_d    = cpu_we_q;
          ram_wdata_d = cpu_wdata_q;
        end
      end
      ST_ACCESS: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q       <= 5'd0;
      char_q      <= 1'b0;
      att_q       <= 1'b0;
      rom_q       <= 1'b0;
      tick_q      <= 1'b0;
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= 8'd0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'd0;
      cpu_addr_q  <= '0;
      cpu_we_q    <= 1'b0;
      cpu_wdata_q <= 8'd0;
    end else begin
      seq_q       <= seq_d;
      char_q      <= char_d;
      att_q       <= att_d;
      rom_q       <= rom_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_we_q    <= cpu_we_d;
      cpu_wdata_q <= cpu_wdata_d;
    end
  end

  assign clk_seq_o        = seq_q;
  assign vram_read_char_o = char_q;
  assign vram_read_att_o  = att_q;
  assign charrom_read_o   = rom_q;
  assign disp_pipeline_o  = rom_q;
  assign char_tick_o      = tick_q;
  assign cpu_ack_o        = ack_q;
  // Read data is presented straight from the VRAM bus during the ack cycle.
  assign cpu_rdata_o      = (ack_q && !cpu_we_q) ? ram_rdata_i : rdata_q;
  assign ram_addr_o       = ram_addr_q;
  // A reset landing on the write cycle must not let the write through.
  assign ram_we_o         = ram_we_q & ~reset;
  assign ram_wdata_o      = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cga_vram_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cga_vram_sequencer
//  Purpose  : Directed self-checking bench for cga_vram_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cga_vram_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hres_mode = 1'b1;
  logic [13:0] vid_addr = 14'h0124;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = 14'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h0;
  logic [4:0]  clk_seq;
  logic        vram_read_char, vram_read_att, charrom_read, disp_pipeline, char_tick;

  int checks = 0;
  int errors = 0;

  cga_vram_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .hres_mode_i      (hres_mode),
    .vid_addr_i       (vid_addr),
    .cpu_req_i        (cpu_req),
    .cpu_we_i         (cpu_we),
    .cpu_addr_i       (cpu_addr),
    .cpu_wdata_i      (cpu_wdata),
    .cpu_ack_o        (cpu_ack),
    .cpu_rdata_o      (cpu_rdata),
    .ram_addr_o       (ram_addr),
    .ram_we_o         (ram_we),
    .ram_wdata_o      (ram_wdata),
    .ram_rdata_i      (ram_rdata),
    .clk_seq_o        (clk_seq),
    .vram_read_char_o (vram_read_char),
    .vram_read_att_o  (vram_read_att),
    .charrom_read_o   (charrom_read),
    .disp_pipeline_o  (disp_pipeline),
    .char_tick_o      (char_tick)
  );

  always #5 clk = ~clk;

  // VRAM model: data one clk after the address, content = addr[7:0] ^ 0xA5
  always @(posedge clk) ram_rdata <= ram_addr[7:0] ^ 8'hA5;

  // Bench-side slot counter
  logic [4:0] exp_seq = 5'd0;
  always @(posedge clk) exp_seq <= reset ? 5'd0 : exp_seq + 5'd1;

  // Advance (at negedges) until the bench counter shows slot s
  task automatic wait_seq(input logic [4:0] s);
    for (int i = 0; i < 40; i++) begin
      if (exp_seq == s) return;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (clk_seq !== 5'd0) begin
      errors++; $display("FAIL reset_clk_seq actual=%0d required=0", clk_seq);
    end
    checks++;
    if ({vram_read_char, vram_read_att, charrom_read, disp_pipeline, char_tick, cpu_ack, ram_we} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes actual=%b required=0000000",
        {vram_read_char, vram_read_att, charrom_read, disp_pipeline, char_tick, cpu_ack, ram_we});
    end
    checks++;
    if ({ram_addr, ram_wdata, cpu_rdata} !== 30'b0) begin
      errors++; $display("FAIL reset_data actual=%h/%h/%h required=0/0/0", ram_addr, ram_wdata, cpu_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (clk_seq !== 5'd1) begin
      errors++; $display("FAIL reset_release_seq actual=%0d required=1", clk_seq);
    end
  endtask

  // 64 clks of video timing; hr selects 80-col, va the fetch address
  task automatic test_video_timing(input logic hr, input logic [13:0] va,
                                   input logic [13:0] even_a, input logic [13:0] odd_a);
    logic e_char, e_att, e_rom, e_tick;
    wait_seq(5'd31);
    hres_mode = hr;
    vid_addr  = va;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e_char = (exp_seq == 5'd1) || (hr && exp_seq == 5'd17);
      e_att  = (exp_seq == 5'd2) || (hr && exp_seq == 5'd18);
      e_rom  = (exp_seq == 5'd3) || (hr && exp_seq == 5'd19);
      e_tick = (exp_seq == 5'd31) || (hr && exp_seq == 5'd15);
      checks++;
      if ({clk_seq, vram_read_char, vram_read_att, charrom_read, disp_pipeline, char_tick} !==
          {exp_seq, e_char, e_att, e_rom, e_rom, e_tick}) begin
        errors++;
        $display("FAIL video_strobes hr=%0b actual seq=%0d ch/at/rom/pipe/tick=%b required seq=%0d %b",
          hr, clk_seq, {vram_read_char, vram_read_att, charrom_read, disp_pipeline, char_tick},
          exp_seq, {e_char, e_att, e_rom, e_rom, e_tick});
      end
      if (exp_seq == 5'd0 || (hr && exp_seq == 5'd16)) begin
        checks++;
        if (ram_addr !== even_a) begin
          errors++; $display("FAIL video_addr_even seq=%0d actual=%h required=%h", exp_seq, ram_addr, even_a);
        end
      end
      if (exp_seq == 5'd1 || (hr && exp_seq == 5'd17)) begin
        checks++;
        if (ram_addr !== odd_a) begin
          errors++; $display("FAIL video_addr_odd seq=%0d actual=%h required=%h", exp_seq, ram_addr, odd_a);
        end
      end
    end
  endtask

  task automatic test_cpu_write();
    int lat;
    bit got;
    hres_mode = 1'b1;
    wait_seq(5'd2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'h5A;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      checks++;
      if (ram_we !== (exp_seq == 5'd8)) begin
        errors++; $display("FAIL wr_we seq=%0d actual=%b required=%b", exp_seq, ram_we, exp_seq == 5'd8);
      end
      if (exp_seq == 5'd8) begin
        checks++;
        if ({ram_addr, ram_wdata} !== {14'h3FFF, 8'h5A}) begin
          errors++; $display("FAIL wr_bus actual=%h/%h required=3fff/5a", ram_addr, ram_wdata);
        end
      end
      if (cpu_ack) begin
        got = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        checks++;
        if (exp_seq !== 5'd9 || lat != 7) begin
          errors++; $display("FAIL wr_ack actual seq=%0d lat=%0d required seq=9 lat=7", exp_seq, lat);
        end
      end
    end
    if (!got) begin
      errors++; $display("FAIL wr_timeout actual=no_ack required=ack");
      cpu_req = 1'b0;
    end
  endtask

  task automatic test_cpu_read();
    int lat;
    bit got;
    hres_mode = 1'b0;
    wait_seq(5'd8);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      checks++;
      if (ram_we !== 1'b0) begin
        errors++; $display("FAIL rd_we seq=%0d actual=%b required=0", exp_seq, ram_we);
      end
      if (exp_seq == 5'd24) begin
        checks++;
        if (ram_addr !== 14'h1234) begin
          errors++; $display("FAIL rd_addr actual=%h required=1234", ram_addr);
        end
      end
      if (cpu_ack) begin
        got = 1'b1;
        cpu_req = 1'b0;
        checks++;
        if (exp_seq !== 5'd25 || lat != 17 || cpu_rdata !== 8'h91) begin
          errors++; $display("FAIL rd_ack actual seq=%0d lat=%0d data=%h required seq=25 lat=17 data=91",
            exp_seq, lat, cpu_rdata);
        end
      end
    end
    if (!got) begin
      errors++; $display("FAIL rd_timeout actual=no_ack required=ack");
      cpu_req = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h91) begin
      errors++; $display("FAIL rd_hold actual ack=%b data=%h required ack=0 data=91", cpu_ack, cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n_ack;
    int since;
    bit e_char;
    hres_mode = 1'b1;
    vid_addr  = 14'h0124;
    wait_seq(5'd4);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0100;
    n_ack = 0; since = 0;
    for (int i = 0; i < 60 && n_ack < 2; i++) begin
      @(negedge clk);
      since++;
      if (n_ack == 1 && !cpu_req) begin
        cpu_req = 1'b1; cpu_addr = 14'h02FF;  // new request the cycle after ack
      end
      e_char = (exp_seq == 5'd1) || (exp_seq == 5'd17);
      checks++;
      if ({vram_read_char, charrom_read} !== {e_char, (exp_seq == 5'd3) || (exp_seq == 5'd19)}) begin
        errors++; $display("FAIL b2b_video seq=%0d actual=%b%b", exp_seq, vram_read_char, charrom_read);
      end
      if (cpu_ack) begin
        cpu_req = 1'b0;
        checks++;
        if (n_ack == 0) begin
          if (exp_seq !== 5'd9 || since != 5 || cpu_rdata !== 8'hA5) begin
            errors++; $display("FAIL b2b_first actual seq=%0d lat=%0d data=%h required seq=9 lat=5 data=a5",
              exp_seq, since, cpu_rdata);
          end
        end else begin
          if (exp_seq !== 5'd25 || since != 16 || cpu_rdata !== 8'h5A) begin
            errors++; $display("FAIL b2b_second actual seq=%0d gap=%0d data=%h required seq=25 gap=16 data=5a",
              exp_seq, since, cpu_rdata);
          end
        end
        n_ack++;
        since = 0;
      end
    end
    checks++;
    if (n_ack != 2) begin
      errors++; $display("FAIL b2b_timeout actual acks=%0d required=2", n_ack);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    hres_mode = 1'b1;
    wait_seq(5'd5);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0AAA; cpu_wdata = 8'h33;
    wait_seq(5'd8);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 14'h0AAA) begin
      errors++; $display("FAIL rst_mid_setup actual we=%b addr=%h required we=1 addr=0aaa", ram_we, ram_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_we actual=%b required=0", ram_we);
    end
    @(negedge clk);
    checks++;
    if (clk_seq !== 5'd0 || cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state actual seq=%0d ack=%b we=%b required 0/0/0", clk_seq, cpu_ack, ram_we);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || clk_seq !== 5'(i + 1)) begin
        errors++; $display("FAIL rst_mid_after cyc=%0d actual ack=%b we=%b seq=%0d required 0/0/%0d",
          i, cpu_ack, ram_we, clk_seq, i + 1);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_video_timing(1'b1, 14'h0124, 14'h0124, 14'h0125);
    test_video_timing(1'b0, 14'h2AB7, 14'h2AB6, 14'h2AB7);
    test_cpu_write();
    test_cpu_read();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
